// File: rtl/tt_gear_status_uart_tx_pkg.sv
// Shared constants for the gear-selector status link: LED bit positions, gear
// ASCII codes, UART state encoding and the status-to-character encoder.
package tt_maquina_pkg;

  localparam int LED_D1 = 0;
  localparam int LED_D2 = 1;
  localparam int LED_D3 = 2;
  localparam int LED_D4 = 3;
  localparam int LED_P1 = 4;
  localparam int LED_N1 = 5;
  localparam int LED_R1 = 6;

  localparam logic [7:0] GEAR_CH_P   = 8'h50;
  localparam logic [7:0] GEAR_CH_R   = 8'h52;
  localparam logic [7:0] GEAR_CH_N   = 8'h4E;
  localparam logic [7:0] GEAR_CH_D1  = 8'h31;
  localparam logic [7:0] GEAR_CH_D2  = 8'h32;
  localparam logic [7:0] GEAR_CH_D3  = 8'h33;
  localparam logic [7:0] GEAR_CH_D4  = 8'h34;
  localparam logic [7:0] GEAR_CH_BAD = 8'h3F;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_e;

  // Anything other than exactly one active gear is reported as '?'.
  function automatic logic [7:0] gear_enc(input logic [6:0] led);
    logic [7:0] ch;
    ch = GEAR_CH_BAD;
    if ((led != 7'd0) && ((led & (led - 7'd1)) == 7'd0)) begin
      if (led[LED_R1])      ch = GEAR_CH_R;
      else if (led[LED_N1]) ch = GEAR_CH_N;
      else if (led[LED_P1]) ch = GEAR_CH_P;
      else if (led[LED_D4]) ch = GEAR_CH_D4;
      else if (led[LED_D3]) ch = GEAR_CH_D3;
      else if (led[LED_D2]) ch = GEAR_CH_D2;
      else if (led[LED_D1]) ch = GEAR_CH_D1;
    end
    return ch;
  endfunction

endpackage

// File: rtl/tt_gear_status_uart_tx_if.sv
// Status-in / UART-out signal bundle between the gear FSM side and the transmitter.
interface tt_gear_status_uart_tx_if;
  logic [6:0] led_in;
  logic       tx;
  logic       busy;

  modport master (output led_in, input tx, input busy);
  modport slave  (input led_in, output tx, output busy);
endinterface

// File: rtl/tt_gear_status_uart_tx_baud_tick.sv
// Bit-period counter: bit_done_o pulses on the last cycle of every bit while enabled.
module tt_baud_tick #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_done_o
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || !en_i || bit_done_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tt_gear_status_uart_tx.sv
// Sends the active gear as one UART character on every status change.
// TT_GEAR_TX_PARITY_EN adds an even-parity bit (8E1); default frame is 8N1.
//
// state  | meaning
// IDLE   | line high, waiting for a status change
// START  | start bit (0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the data byte (parity build only)
// STOP   | stop bit (1); reloads straight into START if a change is pending
module tt_gear_status_uart_tx
  import tt_maquina_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst_n,
  tt_gear_status_uart_tx_if.slave bus
);
  uart_state_e state_q, state_d;
  logic [6:0]  led_q;
  logic [7:0]  data_q, data_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        pending_q, pending_d;
  logic        load;
  logic        bit_done;
  logic        ev;
  logic        tx;

  assign ev = (bus.led_in != led_q);

  tt_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (load),
    .en_i       (state_q != UART_IDLE),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    pending_d = pending_q;
    load      = 1'b0;
    if (ev && (state_q != UART_IDLE)) pending_d = 1'b1;
    case (state_q)
      UART_IDLE: if (ev) begin
        load    = 1'b1;
        data_d  = gear_enc(bus.led_in);
        state_d = UART_START;
      end
      UART_START: if (bit_done) begin
        bit_idx_d = 3'd0;
        state_d   = UART_DATA;
      end
      UART_DATA: if (bit_done) begin
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) begin
`ifdef TT_GEAR_TX_PARITY_EN
          state_d = UART_PARITY;
`else
          state_d = UART_STOP;
`endif
        end
      end
      UART_PARITY: if (bit_done) state_d = UART_STOP;
      UART_STOP: if (bit_done) begin
        // A change in this very cycle is served by the reload, not left pending.
        if (pending_q || ev) begin
          load      = 1'b1;
          data_d    = gear_enc(bus.led_in);
          pending_d = 1'b0;
          state_d   = UART_START;
        end else begin
          state_d = UART_IDLE;
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      UART_START:  tx = 1'b0;
      UART_DATA:   tx = data_q[bit_idx_q];
      UART_PARITY: tx = ^data_q;
      default:     tx = 1'b1;
    endcase
  end

  assign bus.tx   = tx;
  assign bus.busy = (state_q != UART_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= UART_IDLE;
      led_q     <= 7'h00;
      data_q    <= 8'h00;
      bit_idx_q <= 3'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_q     <= bus.led_in;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      pending_q <= pending_d;
    end
  end
endmodule

// File: tb/tb_tt_gear_status_uart_tx.sv
// Bench for tt_gear_status_uart_tx: timeline model of the line plus a UART receiver.
module tb_tt_gear_status_uart_tx;
  localparam int CPB = 4;
`ifdef TT_GEAR_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FC = NB * CPB;
  localparam logic [7:0] CH [7] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h50, 8'h4E, 8'h52};

  logic clk;
  logic rst_n;
  tt_gear_status_uart_tx_if bus();

  tt_gear_status_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line model: a frame is a fixed bit list played out over FC cycles.
  logic       fb [NB];
  logic       m_act = 1'b0, m_pend = 1'b0, m_ev;
  logic [6:0] m_prev = 7'h00;
  int         m_pos = 0;
  logic       exp_tx = 1'b1, exp_busy = 1'b0;
  logic       started = 1'b0;

  function automatic logic [7:0] enc_model(input logic [6:0] l);
    if ($countones(l) != 1) return 8'h3F;
    for (int i = 0; i < 7; i++) if (l[i]) return CH[i];
    return 8'h3F;
  endfunction

  task automatic start_frame(input logic [6:0] l);
    logic [7:0] c;
    c = enc_model(l);
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = c[i];
`ifdef TT_GEAR_TX_PARITY_EN
    fb[9] = ^c;
`endif
    fb[NB-1] = 1'b1;
    m_pos = 0;
    m_act = 1'b1;
  endtask

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      m_act = 1'b0; m_pend = 1'b0; m_prev = 7'h00;
    end else begin
      m_ev = (bus.led_in != m_prev);
      m_prev = bus.led_in;
      if (m_act) begin
        m_pos++;
        if (m_pos == FC) begin
          if (m_pend || m_ev) begin
            start_frame(bus.led_in);
            m_pend = 1'b0;
          end else m_act = 1'b0;
        end else if (m_ev) m_pend = 1'b1;
      end else if (m_ev) start_frame(bus.led_in);
    end
    exp_busy = m_act;
    exp_tx   = m_act ? fb[m_pos / CPB] : 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (bus.tx !== exp_tx || bus.busy !== exp_busy) begin
        miscompares++;
        $display("FAIL line t=%0t: tx=%b busy=%b, expected tx=%b busy=%b",
                 $time, bus.tx, bus.busy, exp_tx, exp_busy);
      end
    end
  end

  // Receiver decoding the line at bit centres.
  logic [7:0] q_byte [$];
  logic       q_par [$];
  int         q_start [$];
  int         cyc = 0, rx_off = 0, rx_start = 0, k;
  logic       rx_act = 1'b0, rx_par = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) rx_act = 1'b0;
    else if (!rx_act) begin
      if (bus.tx == 1'b0) begin
        rx_act = 1'b1; rx_off = 0; rx_start = cyc;
      end
    end else begin
      rx_off++;
      if (rx_off % CPB == CPB / 2) begin
        k = rx_off / CPB;
        if (k >= 1 && k <= 8) rx_byte[k-1] = bus.tx;
        else if (k == NB - 1) begin
          q_byte.push_back(rx_byte);
          q_par.push_back(rx_par);
          q_start.push_back(rx_start);
        end else rx_par = bus.tx;
      end
      if (rx_off == FC - 1) rx_act = 1'b0;
    end
  end

  task automatic clear_q();
    q_byte.delete(); q_par.delete(); q_start.delete();
  endtask

  task automatic set_led(input logic [6:0] v);
    @(posedge clk); #1 bus.led_in = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic int qb(input int i);
    return (q_byte.size() > i) ? int'(q_byte[i]) : -1;
  endfunction

  int n;
  logic [7:0] gears_exp [6] = '{8'h50, 8'h52, 8'h31, 8'h32, 8'h33, 8'h34};
  logic [6:0] gears_in  [6] = '{7'b0010000, 7'b1000000, 7'b0000001,
                                 7'b0000010, 7'b0000100, 7'b0001000};

  initial begin
    rst_n = 1'b0;
    bus.led_in = 7'h00;
    wait_cyc(3);
    #1 rst_n = 1'b1;

    // 1 reset, no frame
    wait_cyc(10);
    @(negedge clk);
    check("t1_busy", bus.busy, 0);
    check("t1_tx", bus.tx, 1);
    check("t1_frames", q_byte.size(), 0);

    // 2 single change
    clear_q();
    set_led(7'b0100000);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else if (n > 0) break;
    end
    check("t2_busy_len", n, FC);
    check("t2_frames", q_byte.size(), 1);
    check("t2_byte", qb(0), 8'h4E);

    // 3 all gears
    clear_q();
    for (int g = 0; g < 6; g++) begin
      set_led(gears_in[g]);
      wait_cyc(FC + 8);
    end
    check("t3_frames", q_byte.size(), 6);
    for (int g = 0; g < 6; g++) check($sformatf("t3_byte%0d", g), qb(g), int'(gears_exp[g]));

    // 4 invalid status
    clear_q();
    set_led(7'b0000011);
    wait_cyc(FC + 8);
    check("t4_byte", qb(0), 8'h3F);

    // 5 coalescing
    clear_q();
    set_led(7'b0000001);
    wait_cyc(12);
    set_led(7'b0000010);
    wait_cyc(8);
    set_led(7'b0000100);
    wait_cyc(2 * FC + 10);
    check("t5_frames", q_byte.size(), 2);
    check("t5_byte0", qb(0), 8'h31);
    check("t5_byte1", qb(1), 8'h33);
    if (q_start.size() == 2) check("t5_gap", q_start[1] - q_start[0], FC);
    else check("t5_gap_frames", q_start.size(), 2);

    // 6 reset mid-frame
    clear_q();
    set_led(7'b0001000);
    wait_cyc(15);
    #1 begin rst_n = 1'b0; bus.led_in = 7'h00; end
    @(posedge clk);
    @(negedge clk);
    check("t6_tx", bus.tx, 1);
    check("t6_busy", bus.busy, 0);
    wait_cyc(2);
    #1 rst_n = 1'b1;
    clear_q();
    wait_cyc(20);
    @(negedge clk);
    check("t6_quiet_frames", q_byte.size(), 0);
    check("t6_quiet_busy", bus.busy, 0);
    set_led(7'b0000010);
    wait_cyc(FC + 8);
    check("t6_byte", qb(0), 8'h32);

`ifdef TT_GEAR_TX_PARITY_EN
    // 7 parity
    clear_q();
    set_led(7'b0100000);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else if (n > 0) break;
    end
    check("t7_len", n, 44);
    check("t7_byteN", qb(0), 8'h4E);
    if (q_par.size() > 0) check("t7_parN", q_par[0], 0);
    else check("t7_parN_frames", q_par.size(), 1);
    clear_q();
    set_led(7'b0000001);
    wait_cyc(FC + 8);
    check("t7_byte1", qb(0), 8'h31);
    if (q_par.size() > 0) check("t7_par1", q_par[0], 1);
    else check("t7_par1_frames", q_par.size(), 1);
`endif

    wait_cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
